decode_stage: RTL and testbench

Instruction-decode stage of the pipelined MIPS core: accepts one instruction per cycle from fetch, reads the 32x32 register file, extracts shift amount and immediate, derives ALUOp, and drives the execute-stage ALU inputs. It owns the register file and its writeback port, inserts a one-cycle bubble on load-use hazards, and squashes in-flight work when execute reports a taken branch.

---
 rtl/decode_stage_if.sv | 30 +++
 rtl/decode_stage.sv | 137 +++++++++++++
 tb/tb_decode_stage.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// Decode-stage bundle: fetch handshake, writeback port, branch flush and execute-side outputs.
// master = fetch/writeback/execute environment, slave = decode_stage.
interface decode_stage_if;
  logic [31:0] pc_in;
  logic [31:0] insn_in;
  logic        insn_valid;
  logic        insn_ready;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        branch_taken;
  logic [31:0] pc;
  logic [31:0] insn;
  logic [31:0] rsData;
  logic [31:0] rtData;
  logic [4:0]  saData;
  logic [31:0] immSXData;
  logic [5:0]  ALUOp;
  logic        enable_execute;

  modport master (
    output pc_in, insn_in, insn_valid, wb_en, wb_addr, wb_data, branch_taken,
    input  insn_ready, pc, insn, rsData, rtData, saData, immSXData, ALUOp, enable_execute
  );

  modport slave (
    input  pc_in, insn_in, insn_valid, wb_en, wb_addr, wb_data, branch_taken,
    output insn_ready, pc, insn, rsData, rtData, saData, immSXData, ALUOp, enable_execute
  );
endinterface

// File: rtl/decode_stage.sv
// MIPS decode stage: register file, immediate/ALUOp decode, load-use stall and branch flush.
// Define DECODE_BYPASS_EN to forward same-cycle writeback data into rsData/rtData.
module decode_stage (
  input logic       clock,
  input logic       reset,
  decode_stage_if.slave dec
);

  localparam logic [5:0] OpSpecial = 6'b000000;
  localparam logic [5:0] OpBeq     = 6'b000100;
  localparam logic [5:0] OpBne     = 6'b000101;
  localparam logic [5:0] OpOri     = 6'b001101;
  localparam logic [5:0] OpXori    = 6'b001110;
  localparam logic [5:0] OpLb      = 6'b100000;
  localparam logic [5:0] OpLw      = 6'b100011;
  localparam logic [5:0] OpLbu     = 6'b100100;
  localparam logic [5:0] OpSb      = 6'b101000;
  localparam logic [5:0] OpSw      = 6'b101011;

  typedef enum logic [0:0] {StRun, StStall} state_e;

  state_e      state_q;
  logic        ready_q;
  logic        en_q;
  logic [31:0] pc_q, insn_q, rs_q, rt_q, imm_q;
  logic [4:0]  sa_q;
  logic [5:0]  aluop_q;
  logic [31:0] rf_q [32];

  logic [5:0]  opcode;
  logic [4:0]  rs_idx, rt_idx, ld_rt;
  logic [31:0] rs_val, rt_val, imm_val;
  logic [5:0]  aluop_val;
  logic        uses_rt, ld_in_out, hazard, xfer, load_en, bubble;

  assign opcode = dec.insn_in[31:26];
  assign rs_idx = dec.insn_in[25:21];
  assign rt_idx = dec.insn_in[20:16];
  assign ld_rt  = insn_q[20:16];
  assign xfer   = dec.insn_valid && ready_q;

  always_comb begin
    rs_val = rf_q[rs_idx];
    rt_val = rf_q[rt_idx];
`ifdef DECODE_BYPASS_EN
    if (dec.wb_en && (dec.wb_addr == rs_idx) && (rs_idx != 5'd0)) rs_val = dec.wb_data;
    if (dec.wb_en && (dec.wb_addr == rt_idx) && (rt_idx != 5'd0)) rt_val = dec.wb_data;
`endif
  end

  always_comb begin
    aluop_val = (opcode == OpSpecial) ? dec.insn_in[5:0] : opcode;
    if ((opcode == OpOri) || (opcode == OpXori)) imm_val = {16'h0000, dec.insn_in[15:0]};
    else imm_val = {{16{dec.insn_in[15]}}, dec.insn_in[15:0]};
  end

  always_comb begin
    uses_rt   = (opcode == OpSpecial) || (opcode == OpBeq) || (opcode == OpBne) ||
                (opcode == OpSw) || (opcode == OpSb);
    ld_in_out = en_q && ((insn_q[31:26] == OpLw) || (insn_q[31:26] == OpLb) ||
                         (insn_q[31:26] == OpLbu));
    hazard    = ld_in_out && (ld_rt != 5'd0) &&
                ((rs_idx == ld_rt) || (uses_rt && (rt_idx == ld_rt)));
    // The instruction held across STALL is taken at the STALL edge, so the bubble is one cycle.
    load_en   = !dec.branch_taken &&
                (((state_q == StRun) && xfer && !hazard) ||
                 ((state_q == StStall) && dec.insn_valid));
    bubble    = dec.branch_taken || ((state_q == StRun) && xfer && hazard);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (dec.wb_en && (dec.wb_addr != 5'd0)) begin
      rf_q[dec.wb_addr] <= dec.wb_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
      ready_q <= 1'b0;
      en_q    <= 1'b0;
      pc_q    <= '0;
      insn_q  <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      sa_q    <= '0;
      imm_q   <= '0;
      aluop_q <= '0;
    end else begin
      en_q <= load_en;
      if (load_en) begin
        pc_q    <= dec.pc_in;
        insn_q  <= dec.insn_in;
        rs_q    <= rs_val;
        rt_q    <= rt_val;
        sa_q    <= dec.insn_in[10:6];
        imm_q   <= imm_val;
        aluop_q <= aluop_val;
      end else if (bubble) begin
        insn_q <= '0;
      end

      if (dec.branch_taken) begin
        state_q <= StRun;
        ready_q <= 1'b1;
      end else begin
        unique case (state_q)
          StRun: begin
            if (xfer && hazard) begin
              state_q <= StStall;
              ready_q <= 1'b0;
            end else begin
              ready_q <= 1'b1;
            end
          end
          StStall: begin
            state_q <= StRun;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign dec.insn_ready     = ready_q;
  assign dec.enable_execute = en_q;
  assign dec.pc             = pc_q;
  assign dec.insn           = insn_q;
  assign dec.rsData         = rs_q;
  assign dec.rtData         = rt_q;
  assign dec.saData         = sa_q;
  assign dec.immSXData      = imm_q;
  assign dec.ALUOp          = aluop_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; expectations follow the build's
// DECODE_BYPASS_EN setting.
module tb_decode_stage;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  decode_stage_if bus ();

  decode_stage dut (
    .clock (clock),
    .reset (reset),
    .dec   (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    bus.pc_in = '0; bus.insn_in = '0; bus.insn_valid = 1'b0; bus.wb_en = 1'b0;
    bus.wb_addr = '0; bus.wb_data = '0; bus.branch_taken = 1'b0;
    #2;
    n_cmp++; if ({bus.pc, bus.insn, bus.rsData, bus.rtData, bus.saData, bus.immSXData,
                  bus.ALUOp, bus.enable_execute} !== '0) begin
      n_err++; $display("FAIL reset_outputs got pc=%h insn=%h en=%b want all zero",
                        bus.pc, bus.insn, bus.enable_execute);
    end
    n_cmp++; if (bus.insn_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_ready got %b want 0", bus.insn_ready);
    end
    step(); step();
    reset = 1'b0;
    step();
    n_cmp++; if (bus.insn_ready !== 1'b1) begin
      n_err++; $display("FAIL ready_after_reset got %b want 1", bus.insn_ready);
    end
    // $5 = 0x1234, then read it back through ADD $7,$5,$5
    bus.wb_en = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h1234;
    step();
    bus.wb_en = 1'b0;
    bus.pc_in = 32'h100; bus.insn_in = 32'h00A53820; bus.insn_valid = 1'b1;
    step();
    n_cmp++; if (bus.rsData !== 32'h1234) begin
      n_err++; $display("FAIL pre_reset_r5 got %h want 00001234", bus.rsData);
    end
    reset = 1'b1;
    #1;
    n_cmp++; if ({bus.pc, bus.insn, bus.rsData, bus.rtData, bus.saData, bus.immSXData,
                  bus.ALUOp, bus.enable_execute, bus.insn_ready} !== '0) begin
      n_err++; $display("FAIL midstream_reset got pc=%h insn=%h rs=%h rdy=%b want all zero",
                        bus.pc, bus.insn, bus.rsData, bus.insn_ready);
    end
    step();
    reset = 1'b0;
    step();
    n_cmp++; if (bus.insn_ready !== 1'b1 || bus.enable_execute !== 1'b0) begin
      n_err++; $display("FAIL ready_after_reset2 got rdy=%b en=%b want rdy=1 en=0",
                        bus.insn_ready, bus.enable_execute);
    end
    step();
    n_cmp++; if (bus.rsData !== 32'h0 || bus.enable_execute !== 1'b1) begin
      n_err++; $display("FAIL r5_cleared got rs=%h en=%b want rs=0 en=1",
                        bus.rsData, bus.enable_execute);
    end
    bus.insn_valid = 1'b0;
    step();
  endtask

  task automatic test_immediate();
    bus.pc_in = 32'h200; bus.insn_in = 32'h2002FFFC; bus.insn_valid = 1'b1;
    step();
    n_cmp++; if (bus.ALUOp !== 6'b001000 || bus.immSXData !== 32'hFFFFFFFC ||
                 bus.enable_execute !== 1'b1 || bus.pc !== 32'h200) begin
      n_err++; $display("FAIL addi_decode got op=%b imm=%h en=%b pc=%h want 001000 FFFFFFFC 1 200",
                        bus.ALUOp, bus.immSXData, bus.enable_execute, bus.pc);
    end
    bus.insn_in = 32'h34038000;
    step();
    n_cmp++; if (bus.immSXData !== 32'h00008000 || bus.ALUOp !== 6'b001101) begin
      n_err++; $display("FAIL ori_zero_ext got imm=%h op=%b want 00008000 001101",
                        bus.immSXData, bus.ALUOp);
    end
    bus.insn_valid = 1'b0;
    step();
    n_cmp++; if (bus.enable_execute !== 1'b0 || bus.insn !== 32'h34038000) begin
      n_err++; $display("FAIL idle_hold got en=%b insn=%h want 0 34038000",
                        bus.enable_execute, bus.insn);
    end
  endtask

  task automatic test_rtype();
    bus.wb_en = 1'b1; bus.wb_addr = 5'd2; bus.wb_data = 32'd7;
    step();
    bus.wb_addr = 5'd3; bus.wb_data = 32'd9;
    step();
    bus.wb_en = 1'b0;
    bus.insn_in = 32'h00432020; bus.insn_valid = 1'b1;
    step();
    n_cmp++; if (bus.ALUOp !== 6'b100000 || bus.rsData !== 32'd7 || bus.rtData !== 32'd9 ||
                 bus.saData !== 5'd0) begin
      n_err++; $display("FAIL add_rtype got op=%b rs=%h rt=%h sa=%0d want 100000 7 9 0",
                        bus.ALUOp, bus.rsData, bus.rtData, bus.saData);
    end
    bus.insn_in = 32'h00032900;
    step();
    n_cmp++; if (bus.saData !== 5'd4 || bus.ALUOp !== 6'b000000 || bus.rtData !== 32'd9) begin
      n_err++; $display("FAIL sll_shamt got sa=%0d op=%b rt=%h want 4 000000 9",
                        bus.saData, bus.ALUOp, bus.rtData);
    end
    bus.insn_valid = 1'b0;
    step();
  endtask

  task automatic test_load_use();
    bus.insn_in = 32'h8C260000; bus.insn_valid = 1'b1;
    step();
    n_cmp++; if (bus.enable_execute !== 1'b1 || bus.insn !== 32'h8C260000) begin
      n_err++; $display("FAIL lw_issue got en=%b insn=%h want 1 8C260000",
                        bus.enable_execute, bus.insn);
    end
    bus.insn_in = 32'h00C63820;
    step();
    n_cmp++; if (bus.insn_ready !== 1'b0 || bus.enable_execute !== 1'b0 ||
                 bus.insn !== 32'h0) begin
      n_err++; $display("FAIL load_use_bubble got rdy=%b en=%b insn=%h want 0 0 0",
                        bus.insn_ready, bus.enable_execute, bus.insn);
    end
    step();
    n_cmp++; if (bus.insn_ready !== 1'b1 || bus.enable_execute !== 1'b1 ||
                 bus.insn !== 32'h00C63820) begin
      n_err++; $display("FAIL add_after_stall got rdy=%b en=%b insn=%h want 1 1 00C63820",
                        bus.insn_ready, bus.enable_execute, bus.insn);
    end
    // ADDI writes rt=$6, so only rs matters: no stall
    bus.insn_in = 32'h8C260000;
    step();
    bus.insn_in = 32'h20260001;
    step();
    n_cmp++; if (bus.insn_ready !== 1'b1 || bus.enable_execute !== 1'b1 ||
                 bus.insn !== 32'h20260001) begin
      n_err++; $display("FAIL addi_rt_no_stall got rdy=%b en=%b insn=%h want 1 1 20260001",
                        bus.insn_ready, bus.enable_execute, bus.insn);
    end
    bus.insn_in = 32'h90290000;
    step();
    bus.insn_in = 32'hAC490004;
    step();
    n_cmp++; if (bus.insn_ready !== 1'b0 || bus.enable_execute !== 1'b0) begin
      n_err++; $display("FAIL lbu_sw_stall got rdy=%b en=%b want 0 0",
                        bus.insn_ready, bus.enable_execute);
    end
    step();
    n_cmp++; if (bus.enable_execute !== 1'b1 || bus.insn !== 32'hAC490004) begin
      n_err++; $display("FAIL sw_after_stall got en=%b insn=%h want 1 AC490004",
                        bus.enable_execute, bus.insn);
    end
    bus.insn_in = 32'h8C200000;
    step();
    bus.insn_in = 32'h00003820;
    step();
    n_cmp++; if (bus.insn_ready !== 1'b1 || bus.enable_execute !== 1'b1 ||
                 bus.insn !== 32'h00003820) begin
      n_err++; $display("FAIL lw_r0_no_stall got rdy=%b en=%b insn=%h want 1 1 00003820",
                        bus.insn_ready, bus.enable_execute, bus.insn);
    end
    bus.insn_valid = 1'b0;
    step();
  endtask

  task automatic test_flush();
    bus.insn_in = 32'h14220003; bus.insn_valid = 1'b1;
    step();
    bus.insn_in = 32'h2002FFFC; bus.branch_taken = 1'b1;
    step();
    n_cmp++; if (bus.enable_execute !== 1'b0 || bus.insn !== 32'h0 ||
                 bus.insn_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_bubble got en=%b insn=%h rdy=%b want 0 0 1",
                        bus.enable_execute, bus.insn, bus.insn_ready);
    end
    bus.branch_taken = 1'b0; bus.insn_valid = 1'b0;
    step();
    n_cmp++; if (bus.enable_execute !== 1'b0 || bus.insn !== 32'h0) begin
      n_err++; $display("FAIL flush_dropped got en=%b insn=%h want 0 0",
                        bus.enable_execute, bus.insn);
    end
    bus.insn_in = 32'h8C260000; bus.insn_valid = 1'b1;
    step();
    bus.insn_in = 32'h00C63820;
    step();
    bus.branch_taken = 1'b1;
    step();
    n_cmp++; if (bus.insn_ready !== 1'b1 || bus.enable_execute !== 1'b0 ||
                 bus.insn !== 32'h0) begin
      n_err++; $display("FAIL flush_in_stall got rdy=%b en=%b insn=%h want 1 0 0",
                        bus.insn_ready, bus.enable_execute, bus.insn);
    end
    bus.branch_taken = 1'b0;
    step();
    n_cmp++; if (bus.enable_execute !== 1'b1 || bus.insn !== 32'h00C63820) begin
      n_err++; $display("FAIL run_after_flush got en=%b insn=%h want 1 00C63820",
                        bus.enable_execute, bus.insn);
    end
    bus.insn_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    bus.insn_valid = 1'b1;
    bus.pc_in = 32'h400; bus.insn_in = 32'h2002FFFC;
    step();
    n_cmp++; if (bus.pc !== 32'h400 || bus.insn !== 32'h2002FFFC || bus.enable_execute !== 1'b1)
    begin
      n_err++; $display("FAIL b2b_0 got pc=%h insn=%h en=%b want 400 2002FFFC 1",
                        bus.pc, bus.insn, bus.enable_execute);
    end
    bus.pc_in = 32'h404; bus.insn_in = 32'h34038000;
    step();
    n_cmp++; if (bus.pc !== 32'h404 || bus.insn !== 32'h34038000 || bus.enable_execute !== 1'b1)
    begin
      n_err++; $display("FAIL b2b_1 got pc=%h insn=%h en=%b want 404 34038000 1",
                        bus.pc, bus.insn, bus.enable_execute);
    end
    bus.pc_in = 32'h408; bus.insn_in = 32'h00432020;
    step();
    n_cmp++; if (bus.pc !== 32'h408 || bus.rsData !== 32'd7 || bus.enable_execute !== 1'b1) begin
      n_err++; $display("FAIL b2b_2 got pc=%h rs=%h en=%b want 408 7 1",
                        bus.pc, bus.rsData, bus.enable_execute);
    end
    bus.insn_valid = 1'b0;
    step();
  endtask

  task automatic test_bypass();
    logic [31:0] exp_rs;
`ifdef DECODE_BYPASS_EN
    exp_rs = 32'hDEADBEEF;
`else
    exp_rs = 32'h00000055;
`endif
    bus.wb_en = 1'b1; bus.wb_addr = 5'd8; bus.wb_data = 32'h55;
    step();
    bus.wb_data = 32'hDEADBEEF;
    bus.insn_in = 32'h01004820; bus.insn_valid = 1'b1;
    step();
    n_cmp++; if (bus.rsData !== exp_rs) begin
      n_err++; $display("FAIL wb_same_cycle got %h want %h", bus.rsData, exp_rs);
    end
    bus.wb_en = 1'b0;
    step();
    n_cmp++; if (bus.rsData !== 32'hDEADBEEF || bus.rtData !== 32'h0) begin
      n_err++; $display("FAIL wb_next_cycle got rs=%h rt=%h want DEADBEEF 0",
                        bus.rsData, bus.rtData);
    end
    bus.insn_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_rtype();
    test_load_use();
    test_flush();
    test_back_to_back();
    test_bypass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
